ks_voice_mixer: RTL and testbench

Parametrised N-voice stereo mixer that sits between multiple ks_string voices and the I2S transmitter, generalising the single-voice, fixed-routing sample path. On each sample tick it snapshots all voice samples, then serially multiply-accumulates one voice per cycle with per-voice gain and pan. It saturates the left and right sums to the audio width and presents them over a valid/ready handshake. Gain, pan and mute come from the SPI register map; overrun is reported back as a sticky status bit.

---
 rtl/ks_voice_mixer.sv | 130 +++++++++++++
 tb/tb_ks_voice_mixer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ks_voice_mixer.sv
// rtl/ks_voice_mixer.sv - N-voice stereo mixer, serial gain/pan MAC with saturating handshake output
module ks_voice_mixer #(
   parameter int NUM_VOICES = 4,
   parameter int DATA_WIDTH = 8,
   parameter int GAIN_WIDTH = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             sample_tick_i,
   input  logic [NUM_VOICES*DATA_WIDTH-1:0] voice_data_i,
   input  logic [NUM_VOICES*GAIN_WIDTH-1:0] gain_i,
   input  logic [NUM_VOICES-1:0]            pan_l_i,
   input  logic [NUM_VOICES-1:0]            pan_r_i,
   input  logic [NUM_VOICES-1:0]            mute_i,
   output logic [DATA_WIDTH-1:0]            l_data_o,
   output logic [DATA_WIDTH-1:0]            r_data_o,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic                             busy_o,
   output logic                             overrun_o,
   input  logic                             clear_overrun_i
);
   localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam int AW = PW + $clog2(NUM_VOICES);
   localparam int IW = $clog2(NUM_VOICES);
   localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
   localparam logic signed [AW-1:0] MAXV = AW'((1 <<< (DATA_WIDTH - 1)) - 1);
   localparam logic signed [AW-1:0] MINV = -AW'(1 <<< (DATA_WIDTH - 1));

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
   state_t state, state_nx;

   logic [NUM_VOICES*DATA_WIDTH-1:0] snap_data;
   logic [NUM_VOICES*GAIN_WIDTH-1:0] snap_gain;
   logic [NUM_VOICES-1:0]            snap_pan_l, snap_pan_r, snap_mute;
   logic [IW-1:0]                    idx;
   logic signed [AW-1:0]             acc_l, acc_r;

   logic signed [DATA_WIDTH-1:0] cur_sample;
   logic [GAIN_WIDTH-1:0]        cur_gain;
   logic signed [PW-1:0]         prod;
   logic                         handshake, take_tick, drop_tick;

   assign cur_sample = snap_data[idx*DATA_WIDTH +: DATA_WIDTH];
   assign cur_gain   = snap_gain[idx*GAIN_WIDTH +: GAIN_WIDTH];
   // gain is unsigned: zero-extend before the signed multiply
   assign prod       = PW'(cur_sample) * PW'($signed({1'b0, cur_gain}));
   assign handshake  = out_valid_o && out_ready_i;
   assign busy_o     = (state == ACC);

   function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] s;
      s = a >>> (GAIN_WIDTH - 1);
      if (s > MAXV)      sat = MAXV[DATA_WIDTH-1:0];
      else if (s < MINV) sat = MINV[DATA_WIDTH-1:0];
      else               sat = s[DATA_WIDTH-1:0];
   endfunction

   always_comb begin
      state_nx  = state;
      take_tick = 1'b0;
      drop_tick = 1'b0;
      case (state)
         IDLE: begin
            if (sample_tick_i) begin
               take_tick = 1'b1;
               state_nx  = ACC;
            end
         end
         ACC: begin
            drop_tick = sample_tick_i;
            if (idx == LAST) state_nx = OUT;
         end
         OUT: begin
            // a tick coinciding with the handshake starts the next frame directly
            if (handshake) begin
               take_tick = sample_tick_i;
               state_nx  = sample_tick_i ? ACC : IDLE;
            end else begin
               drop_tick = sample_tick_i;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         idx         <= '0;
         acc_l       <= '0;
         acc_r       <= '0;
         snap_data   <= '0;
         snap_gain   <= '0;
         snap_pan_l  <= '0;
         snap_pan_r  <= '0;
         snap_mute   <= '0;
         l_data_o    <= '0;
         r_data_o    <= '0;
         out_valid_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         state <= state_nx;
         if (take_tick) begin
            snap_data  <= voice_data_i;
            snap_gain  <= gain_i;
            snap_pan_l <= pan_l_i;
            snap_pan_r <= pan_r_i;
            snap_mute  <= mute_i;
            acc_l      <= '0;
            acc_r      <= '0;
            idx        <= '0;
         end else if (state == ACC) begin
            if (snap_pan_l[idx] && !snap_mute[idx]) acc_l <= acc_l + AW'(prod);
            if (snap_pan_r[idx] && !snap_mute[idx]) acc_r <= acc_r + AW'(prod);
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
         end
         // first OUT cycle has valid low; that is where the result is registered
         if (state == OUT && !out_valid_o) begin
            l_data_o    <= sat(acc_l);
            r_data_o    <= sat(acc_r);
            out_valid_o <= 1'b1;
         end else if (handshake) begin
            out_valid_o <= 1'b0;
         end
         if (drop_tick)            overrun_o <= 1'b1;
         else if (clear_overrun_i) overrun_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ks_voice_mixer.sv
// tb/tb_ks_voice_mixer.sv - directed and randomized checks of ks_voice_mixer against an arithmetic model
module tb_ks_voice_mixer;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int GW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            tick;
   logic [N*DW-1:0] voice_data;
   logic [N*GW-1:0] gain;
   logic [N-1:0]    pan_l, pan_r, mute;
   logic [DW-1:0]   l_data, r_data;
   logic            out_valid, out_ready, busy, overrun, clear_overrun;

   int total = 0;
   int bad   = 0;
   int vs[N];
   int gs[N];
   logic [N-1:0] pl, pr, mu;

   always #5 clk = ~clk;

   ks_voice_mixer #(.NUM_VOICES(N), .DATA_WIDTH(DW), .GAIN_WIDTH(GW)) dut (
      .clk_i(clk), .rst_i(rst), .sample_tick_i(tick),
      .voice_data_i(voice_data), .gain_i(gain),
      .pan_l_i(pan_l), .pan_r_i(pan_r), .mute_i(mute),
      .l_data_o(l_data), .r_data_o(r_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .busy_o(busy), .overrun_o(overrun), .clear_overrun_i(clear_overrun)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // expected mix: sum of sample*gain, divided by 2^(GW-1) rounding toward -inf, clamped
   function automatic int mix(input bit left);
      int s = 0;
      int d = 1 << (GW - 1);
      for (int k = 0; k < N; k++)
         if ((left ? pl[k] : pr[k]) && !mu[k]) s += vs[k] * gs[k];
      if (s >= 0) s = s / d;
      else        s = -((-s + d - 1) / d);
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   task automatic apply();
      for (int k = 0; k < N; k++) begin
         voice_data[k*DW +: DW] = DW'(vs[k]);
         gain[k*GW +: GW]       = GW'(gs[k]);
      end
      pan_l = pl;
      pan_r = pr;
      mute  = mu;
   endtask

   task automatic scramble();
      voice_data = (N*DW)'($urandom);
      gain       = (N*GW)'($urandom);
      pan_l      = N'($urandom);
      pan_r      = N'($urandom);
      mute       = N'($urandom);
   endtask

   task automatic set_all(input int v, input int g);
      for (int k = 0; k < N; k++) begin
         vs[k] = v;
         gs[k] = g;
      end
   endtask

   task automatic randomize_voices();
      for (int k = 0; k < N; k++) begin
         vs[k] = int'($urandom_range(255)) - 128;
         gs[k] = int'($urandom_range(15));
      end
      pl = N'($urandom);
      pr = N'($urandom);
      mu = N'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_frame(input string tag, input int el, input int er, input int hold);
      int n;
      apply();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      scramble();
      check({tag, "_busy"}, int'(busy), 1);
      wait_valid(n);
      check({tag, "_lat"}, n, 5);
      check({tag, "_l"}, int'($signed(l_data)), el);
      check({tag, "_r"}, int'($signed(r_data)), er);
      repeat (hold) @(negedge clk);
      check({tag, "_hold_v"}, int'(out_valid), 1);
      check({tag, "_hold_l"}, int'($signed(l_data)), el);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_vdrop"}, int'(out_valid), 0);
   endtask

   initial begin
      int n, el, er, seen;
      rst = 1'b1; tick = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0;
      voice_data = '0; gain = '0; pan_l = '0; pan_r = '0; mute = '0;
      repeat (2) @(negedge clk);
      check("rst_l", int'(l_data), 0);
      check("rst_r", int'(r_data), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ovr", int'(overrun), 0);
      rst = 1'b0;

      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ready", int'(out_valid), 0);
      out_ready = 1'b0;

      vs = '{10, 20, 30, 40}; set_all(10, 8); vs = '{10, 20, 30, 40};
      pl = '1; pr = '1; mu = '0;
      do_frame("basic", 100, 100, 3);

      set_all(100, 8);
      do_frame("sat_pos", 127, 127, 1);
      set_all(-100, 8);
      do_frame("sat_neg", -128, -128, 0);

      set_all(0, 8); vs[0] = -3; gs[0] = 4; mu = 4'b1110;
      do_frame("floor", -2, -2, 0);
      vs[0] = 5; gs[0] = 15;
      do_frame("gain15", 9, 9, 0);

      set_all(0, 8); vs = '{50, 20, 60, 0};
      pl = 4'b0101; pr = 4'b0110; mu = 4'b0100;
      do_frame("panmute", 50, 20, 1);

      pl = '1; pr = '1; mu = '1; set_all(77, 9);
      do_frame("allmute", 0, 0, 0);

      // overrun: second tick lands in ACC
      set_all(0, 8); vs = '{10, 20, 30, 40}; pl = '1; pr = '1; mu = '0;
      apply();
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      @(negedge clk);
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      check("ovr_set", int'(overrun), 1);
      wait_valid(n);
      check("ovr_lat", n, 3);
      check("ovr_l", int'($signed(l_data)), 100);
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      check("ovr_out_keep", int'(overrun), 1);
      check("ovr_out_valid", int'(out_valid), 1);
      check("ovr_out_r", int'($signed(r_data)), 100);
      clear_overrun = 1'b1; @(negedge clk); clear_overrun = 1'b0;
      check("ovr_clear", int'(overrun), 0);
      tick = 1'b1; clear_overrun = 1'b1; @(negedge clk); tick = 1'b0; clear_overrun = 1'b0;
      check("ovr_setwins", int'(overrun), 1);
      clear_overrun = 1'b1; @(negedge clk); clear_overrun = 1'b0;
      check("ovr_clear2", int'(overrun), 0);

      // tick together with handshake starts a new frame
      randomize_voices(); el = mix(1'b1); er = mix(1'b0);
      apply();
      tick = 1'b1; out_ready = 1'b1; @(negedge clk); tick = 1'b0; out_ready = 1'b0;
      scramble();
      check("hs_tick_valid", int'(out_valid), 0);
      check("hs_tick_busy", int'(busy), 1);
      check("hs_tick_ovr", int'(overrun), 0);
      wait_valid(n);
      check("hs_tick_lat", n, 5);
      check("hs_tick_l", int'($signed(l_data)), el);
      check("hs_tick_r", int'($signed(r_data)), er);
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

      // reset in the middle of ACC discards the frame
      set_all(100, 8); vs = '{10, 20, 30, 40}; pl = '1; pr = '1; mu = '0;
      do_frame("pre_rst", 100, 100, 0);
      apply();
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      @(negedge clk);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_l", int'(l_data), 0);
      check("mid_rst_r", int'(r_data), 0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_rst_novalid", seen, 0);
      do_frame("post_rst", 100, 100, 0);

      for (int i = 0; i < 25; i++) begin
         randomize_voices();
         do_frame($sformatf("rnd%0d", i), mix(1'b1), mix(1'b0), int'($urandom_range(3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
